// File: rtl/oreg_deskew.sv
// Output border of the systolic array: de-skews per-column results into aligned
// rows and buffers them in a show-ahead FIFO drained over a valid/ready handshake.
module oreg_deskew #(
   parameter int WIDTH = 16,
   parameter int COLS  = 4,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          clr,
   input  logic [COLS-1:0]               i_valid,
   input  logic [COLS*WIDTH-1:0]         i_data,
   input  logic                          o_ready,
   output logic                          o_valid,
   output logic [COLS*WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH+1)-1:0]    o_count,
   output logic                          o_overflow,
   output logic                          o_skew_err
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [COLS-1:0]       slot_v;
   logic [COLS*WIDTH-1:0] slot_d;

   // Column c is delayed by COLS-1-c advancing cycles so that all columns of a row line up.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int L = COLS - 1 - c;
      if (L == 0) begin : g_pass
         assign slot_v[c]                 = i_valid[c];
         assign slot_d[c*WIDTH +: WIDTH]  = i_data[c*WIDTH +: WIDTH];
      end else begin : g_dly
         logic [L-1:0]     v_q;
         logic [WIDTH-1:0] d_q [L];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= '0;
               for (int k = 0; k < L; k++) d_q[k] <= '0;
            end else if (clr) begin
               v_q <= '0;
               for (int k = 0; k < L; k++) d_q[k] <= '0;
            end else if (en) begin
               v_q[0] <= i_valid[c];
               d_q[0] <= i_data[c*WIDTH +: WIDTH];
               for (int k = 1; k < L; k++) begin
                  v_q[k] <= v_q[k-1];
                  d_q[k] <= d_q[k-1];
               end
            end
         end
         assign slot_v[c]                = v_q[L-1];
         assign slot_d[c*WIDTH +: WIDTH] = d_q[L-1];
      end
   end

   logic                  row_ok, row_bad, push, pop, full, wr_en;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d, skew_q, skew_d;
   logic [COLS*WIDTH-1:0] mem_q [DEPTH];

   assign row_ok  = &slot_v;
   assign row_bad = (|slot_v) & ~row_ok;
   assign push    = en & row_ok;
   assign pop     = o_valid & o_ready;
   assign full    = (count_q == CNT_W'(DEPTH));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      skew_d   = skew_q;
      wr_en    = 1'b0;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         skew_d   = 1'b0;
      end else begin
         // A full FIFO still takes the row when the head leaves in the same cycle.
         if (push && (!full || pop)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (push && full && !pop) ovf_d = 1'b1;
         if (en && row_bad) skew_d = 1'b1;
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         skew_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         skew_q   <= skew_d;
      end
   end

   // Row storage needs no reset: an empty FIFO masks its output to zero.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= slot_d;
   end

   assign o_valid    = (count_q != '0);
   assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
   assign o_count    = count_q;
   assign o_overflow = ovf_q;
   assign o_skew_err = skew_q;

endmodule

// File: tb/tb_oreg_deskew.sv
// Scoreboard bench for oreg_deskew: a queue-based reference model predicts
// every accepted row, occupancy and sticky flag; a monitor checks each cycle.
module tb_oreg_deskew;

   localparam int W  = 16;
   localparam int C  = 4;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic              clk = 1'b0;
   logic              rst_n, en, clr, o_ready;
   logic [C-1:0]      i_valid;
   logic [C*W-1:0]    i_data;
   logic              o_valid, o_overflow, o_skew_err;
   logic [C*W-1:0]    o_data;
   logic [CW-1:0]     o_count;

   oreg_deskew #(.WIDTH(W), .COLS(C), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
      .o_valid(o_valid), .o_data(o_data), .o_count(o_count),
      .o_overflow(o_overflow), .o_skew_err(o_skew_err));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference state: expected FIFO contents and flags after the last edge.
   logic [C*W-1:0] sb[$];
   bit             exp_ovf, exp_skew;
   // Inputs captured on past advancing cycles (what the array has seen).
   logic [C-1:0]   hv[$];
   logic [C*W-1:0] hd[$];
   // Row generator history: rows started on past advancing cycles.
   bit             gs[$];
   logic [C*W-1:0] gr[$];
   int             gdrop[$];
   // Prediction for the upcoming edge.
   bit             p_valid, p_clr, p_en, p_push, p_ovf, p_skew;
   logic [C*W-1:0] p_row, p_in_d;
   logic [C-1:0]   p_in_v;

   task automatic chk(string nm, logic [C*W-1:0] act, logic [C*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic hist_reset();
      hv.delete(); hd.delete();
      for (int i = 0; i < C-1; i++) begin
         hv.push_back('0);
         hd.push_back('0);
      end
   endtask

   task automatic gen_reset();
      gs.delete(); gr.delete(); gdrop.delete();
   endtask

   task automatic model_reset();
      sb.delete();
      exp_ovf  = 1'b0;
      exp_skew = 1'b0;
      hist_reset();
      gen_reset();
      p_valid = 1'b0;
   endtask

   task automatic commit();
      if (!p_valid) return;
      if (p_clr) begin
         sb.delete();
         exp_ovf  = 1'b0;
         exp_skew = 1'b0;
         hist_reset();
      end else begin
         if (p_push) sb.push_back(p_row);
         exp_ovf  = exp_ovf | p_ovf;
         exp_skew = exp_skew | p_skew;
         if (p_en) begin
            hv.push_back(p_in_v);
            hd.push_back(p_in_d);
            while (hv.size() > C-1) begin
               void'(hv.pop_front());
               void'(hd.pop_front());
            end
         end
      end
      p_valid = 1'b0;
   endtask

   function automatic logic [C*W-1:0] rand_row();
      logic [C*W-1:0] r;
      for (int i = 0; i < C; i++) r[i*W +: W] = W'($urandom);
      return r;
   endfunction

   // One clock cycle: st starts a new row on column 0, drop withholds one column's valid.
   task automatic step(bit e, bit cl, bit rdy, bit st, int drop);
      logic [C*W-1:0] row, d, sd, tmp;
      logic [C-1:0]   v, sv;
      int             cnt, idx, L;
      bit             pop, ok, bd;
      @(posedge clk);
      #1;
      commit();
      row = rand_row();
      d   = rand_row();
      v   = '0;
      for (int c = 0; c < C; c++) begin
         if (c == 0) begin
            if (st && drop != 0) begin
               v[0] = 1'b1;
               d[0 +: W] = row[0 +: W];
            end
         end else begin
            idx = gs.size() - c;
            if (idx >= 0 && gs[idx] && gdrop[idx] != c) begin
               tmp = gr[idx];
               v[c] = 1'b1;
               d[c*W +: W] = tmp[c*W +: W];
            end
         end
      end
      en = e; clr = cl; o_ready = rdy; i_valid = v; i_data = d;
      if (cl) gen_reset();
      else if (e) begin
         gs.push_back(st); gr.push_back(row); gdrop.push_back(drop);
         while (gs.size() > C-1) begin
            void'(gs.pop_front()); void'(gr.pop_front()); void'(gdrop.pop_front());
         end
      end
      // Column c of the aligned slot is the input seen C-1-c advancing cycles ago.
      for (int c = 0; c < C; c++) begin
         L = C - 1 - c;
         if (L == 0) begin
            sv[c] = v[c];
            sd[c*W +: W] = d[c*W +: W];
         end else begin
            sv[c] = hv[hv.size()-L][c];
            tmp   = hd[hd.size()-L];
            sd[c*W +: W] = tmp[c*W +: W];
         end
      end
      cnt = sb.size();
      pop = rdy && (cnt > 0);
      ok  = &sv;
      bd  = (|sv) && !ok;
      p_valid = 1'b1;
      p_clr   = cl;
      p_en    = e;
      p_in_v  = v;
      p_in_d  = d;
      p_row   = sd;
      p_push  = e && ok && (cnt < D || pop);
      p_ovf   = e && ok && (cnt == D) && !pop;
      p_skew  = e && bd;
   endtask

   task automatic idle(int n, bit rdy);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, rdy, 1'b0, -1);
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_valid"}, C*W'(o_valid), '0);
      chk({tag, "_data"},  o_data, '0);
      chk({tag, "_count"}, C*W'(o_count), '0);
      chk({tag, "_ovf"},   C*W'(o_overflow), '0);
      chk({tag, "_skew"},  C*W'(o_skew_err), '0);
   endtask

   // Monitor: compares DUT state with the scoreboard and retires popped rows.
   initial begin
      logic [C*W-1:0] exp_row;
      forever begin
         @(negedge clk);
         chk("count", C*W'(o_count), C*W'(sb.size()));
         chk("valid", C*W'(o_valid), C*W'(sb.size() != 0));
         chk("overflow", C*W'(o_overflow), C*W'(exp_ovf));
         chk("skew_err", C*W'(o_skew_err), C*W'(exp_skew));
         if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL pop_unexpected actual=%0h required=none at %0t", o_data, $time);
            end else begin
               exp_row = sb.pop_front();
               chk("row", o_data, exp_row);
            end
         end else if (!o_valid) begin
            chk("idle_data", o_data, '0);
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; o_ready = 1'b0;
      i_valid = '0; i_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      #1 rst_n = 1'b1;

      // Single row, then the same row with a stall in its third cycle.
      step(1, 0, 1, 1, -1);
      idle(7, 1'b1);
      step(1, 0, 1, 1, -1);
      step(1, 0, 1, 0, -1);
      step(0, 0, 1, 0, -1);
      idle(6, 1'b1);

      // Overflow: five back-to-back rows into a blocked FIFO, then drain.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, -1);
      idle(5, 1'b0);
      idle(6, 1'b1);
      step(1, 1, 1, 0, -1);
      idle(2, 1'b1);

      // Full FIFO with a pop on the same cycle as each new push.
      for (int i = 0; i < 10; i++) step(1, 0, i >= 7, i < 8, -1);
      idle(8, 1'b1);

      // Skew error on column 2, then well-formed rows.
      step(1, 0, 1, 1, 2);
      step(1, 0, 1, 1, -1);
      step(1, 0, 1, 1, -1);
      idle(6, 1'b1);

      // Flush with three rows buffered and one mid-skew.
      for (int i = 0; i < 6; i++) step(1, 0, 0, (i < 3) || (i == 5), -1);
      step(1, 1, 0, 0, -1);
      idle(6, 1'b1);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, C-1)) : -1);
      end

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 6; i++) step(1, 0, i > 3, 1, -1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      model_reset();
      en = 1'b0; clr = 1'b0; o_ready = 1'b0; i_valid = '0; i_data = '0;
      #1;
      check_zero("async_rst");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, -1);
      idle(8, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oreg_deskew.md
# oreg_deskew

Output-side border block of the systolic array: the far end of the skewed-operand path that starts at the input border registers. Result columns leave the array skewed by one cycle per column. The block de-skews them into aligned rows and buffers the rows in a small FIFO. It presents the rows to the writeback path over a valid/ready handshake, and shares the array's `en` (stall) and `clr` (flush) controls.

## Interface
- `WIDTH`, 16, bit width of one column result
- `COLS`, 4, number of array columns (≥1)
- `DEPTH`, 4, FIFO depth in rows (power of two, ≥2)

- `clk` in 1 — clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `en` in 1 — array advance enable; 0 freezes the de-skew stage
- `clr` in 1 — synchronous flush of the whole block
- `i_valid` in COLS — per-column result valid; bit c is column c
- `i_data` in COLS*WIDTH — column c occupies bits [c*WIDTH +: WIDTH]
- `o_ready` in 1 — downstream accepts the head row
- `o_valid` out 1 — FIFO non-empty
- `o_data` out COLS*WIDTH — head row, same packing as `i_data`
- `o_count` out $clog2(DEPTH+1) — rows held in FIFO
- `o_overflow` out 1 — sticky: an aligned row was dropped because the FIFO was full
- `o_skew_err` out 1 — sticky: an aligned slot had mixed column valids

## Operation
- **De-skew stage**
  - Column c passes through COLS-1-c register stages (valid + data).
  - Column COLS-1 is combinational pass-through.
  - All stages load only when `en`=1 and hold when `en`=0.
- **Aligned slot**
  - The stage outputs form one aligned slot.
  - `row_ok` = all delayed valids 1. `row_bad` = delayed valids neither all 1 nor all 0.
- **Push**
  - `push` = `en` & `row_ok`.
  - `en`=0 never pushes, so a frozen slot is not duplicated.
  - `en` & `row_bad` sets `o_skew_err`; nothing is pushed for that slot.
- **FIFO**
  - Show-ahead FIFO, DEPTH entries.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. `o_count` tracks occupancy separately.
- **Pop**
  - `pop` = `o_valid` & `o_ready`.
  - Pops proceed regardless of `en`; the output side is never stalled by the array.
- **Full**
  - When full, push is accepted only if a pop occurs in the same cycle; `o_count` stays DEPTH.
  - Otherwise the row is dropped, `o_overflow` is set, and the FIFO is unchanged.
- **Empty**
  - `o_valid`=0 and `o_data` reads 0.
  - When empty, simultaneous push and pop cannot occur because `pop` requires `o_valid`.
- **o_count**
  - push only: +1. pop only: −1. Both or neither: unchanged.
- **Priority**
  - `rst_n` > `clr` > normal operation.
- **clr**
  - Zeros all de-skew stage valids and data, both pointers, `o_count`, `o_overflow` and `o_skew_err`.
  - Any push or pop in the same cycle is discarded.
- **Sticky flags**
  - Cleared only by reset or `clr`.

## Timing
- **Reset values:** `o_valid`=0, `o_data`=0, `o_count`=0, `o_overflow`=0, `o_skew_err`=0. All stage valids and data are 0, and the pointers are 0.
- **Skew convention:** column c of one row is presented at cycle t+c with `en`=1 throughout.
- **Latency:**
  - The row is aligned combinationally at cycle t+COLS-1 and written at that clock edge.
  - `o_valid`=1 and `o_data` shows the row from cycle t+COLS.
  - With COLS=1, `o_valid` rises at t+1.
- **With stalls:** every `en`=0 cycle between t and t+COLS-1 adds one cycle of latency.
- **Throughput:** one row per cycle sustained when `o_ready`=1.
- **Pop timing:** a pop at cycle k exposes the next entry, or `o_valid`=0, at cycle k+1.
- **Flag timing:** `o_overflow` and `o_skew_err` assert the cycle after the offending edge.
- **clr timing:** `clr` at cycle k gives `o_valid`=0 and `o_count`=0 at k+1. A row half-way through the de-skew stage at k is lost.
- **Reset mid-operation:** asynchronous assertion forces all outputs to their reset values immediately. Operation resumes on the first edge after release.

## Test plan
- **Single row** (COLS=4, WIDTH=16): columns 0..3 carry 0x0011, 0x0022, 0x0033, 0x0044 with valid at cycles 0, 1, 2, 3 and `o_ready`=1.
  - Required: `o_valid`=1 only at cycle 4, with `o_data`=0x0044_0033_0022_0011, `o_count`=1 at cycle 4 and 0 at cycle 5.
- **Stall mid-skew:** same row, `en`=0 during cycle 2.
  - Required: `o_valid` rises at cycle 5 with the identical row, exactly one push, and `o_count` never exceeds 1.
- **Overflow:** `o_ready`=0 with 5 back-to-back rows R0..R4.
  - Required: `o_count`=4, `o_overflow`=1 after R4's edge, pops then return R0..R3 in order, and R4 is never seen.
- **Full with simultaneous pop:** FIFO full and `o_ready`=1 while a new row pushes.
  - Required: `o_count` stays 4, `o_overflow`=0, and the new row appears 4 pops later.
- **Skew error:** column 2's valid withheld for one row.
  - Required: nothing pushed for that row, `o_skew_err`=1 from the next cycle, and following well-formed rows still push normally.
- **Flush and reset:** `clr` pulse with 3 rows buffered and one row mid-skew.
  - Required: `o_valid`=0, `o_count`=0 and the flags cleared the next cycle, with no later output from the discarded rows.
  - Then assert `rst_n`=0 asynchronously mid-stream. Required: all outputs are 0 before the next edge.
